// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard / forwarding scoreboard.
//   stage_rec_t : per-stage destination record {v, rd, wr, ld}
//   FWD_RF      : forward-select value meaning "use register file"
//   STG_*       : stage indices with fixed meaning
// rd is held at RA_MAX bits so the record type can live here while the
// register-address width stays a parameter of the top (RA_W <= RA_MAX).
package hazard_scoreboard_pkg;

  localparam int unsigned RA_MAX    = 8;
  localparam int unsigned FWD_RF    = 0;
  localparam int unsigned STG_IDEX  = 0;
  // Stage whose data-memory access can hold the whole pipeline.
  localparam int unsigned STG_EXMEM = 1;

  typedef struct packed {
    logic              v;
    logic [RA_MAX-1:0] rd;
    logic              wr;
    logic              ld;
  } stage_rec_t;

endpackage

// File: rtl/hazard_scoreboard_hs_match.sv
// hs_match: combinational nearest-writer search over the stage records.
// Ports:
//   recs    : stage records, index 0 = youngest (ID/EX)
//   src     : source register address (zero-extended to RA_MAX)
//   use_src : source is actually read
//   hit     : some stage in FIRST..DEPTH-1 writes src
//   idx     : lowest matching stage index
//   is_ld   : the winning stage holds a load
// Register 0 never matches.
module hs_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned FIRST = 0,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  stage_rec_t [DEPTH-1:0] recs,
  input  logic [RA_MAX-1:0]      src,
  input  logic                   use_src,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic                   is_ld
);

  // Walk from oldest to youngest so the lowest matching index is the last write.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    is_ld = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (i >= int'(FIRST) && use_src && recs[i].v && recs[i].wr &&
          recs[i].rd != '0 && recs[i].rd == src) begin
        hit   = 1'b1;
        idx   = IDX_W'(i);
        is_ld = recs[i].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall / flush / freeze / forwarding control for the
// in-order pipeline. Tracks the destination of every instruction from ID/EX
// (stage 0) to the last stage before register-file write (stage DEPTH-1).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_*                      : decode of the instruction currently in ID
//   mem_ready                 : 0 while a data-memory access is pending
//   pc_write, ifid_write      : 0 = hold PC / IF-ID
//   idex_bubble               : insert a bubble into ID/EX
//   ifid_flush                : clear IF/ID after a redirect
//   freeze                    : hold every pipeline register
//   fwd_a, fwd_b              : EX operand source, 0 = regfile, k = stage k
//   stall_cnt, freeze_cnt     : saturating event counters, present only when
//                               HAZARD_PERF_CNT_EN is defined
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned BR_WAIT    = 2,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned FWD_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_wr,
  input  logic             id_mem_rd,
  input  logic             id_is_branch,
  input  logic             id_jump,
  input  logic             id_br_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             freeze,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      freeze_cnt
`endif
);

  stage_rec_t [DEPTH-1:0] recs_q, recs_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic            ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;

  logic             id_a_hit, id_b_hit, id_a_ld, id_b_ld;
  logic             ex_a_hit, ex_b_hit, ex_a_ld, ex_b_ld;
  logic [FWD_W-1:0] id_a_idx, id_b_idx, ex_a_idx, ex_b_idx;

  hs_match #(.DEPTH(DEPTH), .FIRST(0), .IDX_W(FWD_W)) u_match_id_rs (
    .recs(recs_q), .src(RA_MAX'(id_rs)), .use_src(id_use_rs),
    .hit(id_a_hit), .idx(id_a_idx), .is_ld(id_a_ld)
  );
  hs_match #(.DEPTH(DEPTH), .FIRST(0), .IDX_W(FWD_W)) u_match_id_rt (
    .recs(recs_q), .src(RA_MAX'(id_rt)), .use_src(id_use_rt),
    .hit(id_b_hit), .idx(id_b_idx), .is_ld(id_b_ld)
  );
  // The EX consumer sits in stage 0 itself, so its producers start at stage 1.
  hs_match #(.DEPTH(DEPTH), .FIRST(1), .IDX_W(FWD_W)) u_match_ex_rs (
    .recs(recs_q), .src(RA_MAX'(ex_rs_q)), .use_src(ex_use_rs_q),
    .hit(ex_a_hit), .idx(ex_a_idx), .is_ld(ex_a_ld)
  );
  hs_match #(.DEPTH(DEPTH), .FIRST(1), .IDX_W(FWD_W)) u_match_ex_rt (
    .recs(recs_q), .src(RA_MAX'(ex_rt_q)), .use_src(ex_use_rt_q),
    .hit(ex_b_hit), .idx(ex_b_idx), .is_ld(ex_b_ld)
  );

  // A load at stage k is still short of data next cycle if k+1 < LOAD_STAGE.
  logic lu_a, lu_b, br_a, br_b, stall_raw, mem_freeze, br_redirect;

  assign lu_a = id_a_hit && id_a_ld && (32'(id_a_idx) + 32'd1 < LOAD_STAGE);
  assign lu_b = id_b_hit && id_b_ld && (32'(id_b_idx) + 32'd1 < LOAD_STAGE);
  assign br_a = id_is_branch && id_a_hit && (32'(id_a_idx) < BR_WAIT);
  assign br_b = id_is_branch && id_b_hit && (32'(id_b_idx) < BR_WAIT);

  assign stall_raw   = id_valid && (lu_a || lu_b || br_a || br_b);
  assign mem_freeze  = !mem_ready && recs_q[STG_EXMEM].v && recs_q[STG_EXMEM].ld;
  assign br_redirect = (id_br_taken && id_is_branch) || id_jump;

  // Outputs: freeze > stall > flush; rst forces reset values immediately.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    fwd_a       = FWD_W'(FWD_RF);
    fwd_b       = FWD_W'(FWD_RF);
    if (!rst) begin
      if (mem_freeze) begin
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (stall_raw) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (br_redirect) begin
        ifid_flush = 1'b1;
      end
      // A load whose data is not yet available is never a forwarding source.
      if (ex_a_hit && !(ex_a_ld && 32'(ex_a_idx) < LOAD_STAGE)) fwd_a = ex_a_idx;
      if (ex_b_hit && !(ex_b_ld && 32'(ex_b_idx) < LOAD_STAGE)) fwd_b = ex_b_idx;
    end
  end

  always_comb begin
    recs_d      = recs_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_use_rs_d = ex_use_rs_q;
    ex_use_rt_d = ex_use_rt_q;
    if (!mem_freeze) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        recs_d[k] = recs_q[k-1];
      end
      recs_d[STG_IDEX].v  = id_valid && !stall_raw;
      recs_d[STG_IDEX].rd = RA_MAX'(id_rd);
      recs_d[STG_IDEX].wr = id_reg_wr;
      recs_d[STG_IDEX].ld = id_mem_rd;
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      // Bubbles carry no live sources, so they never request forwarding.
      ex_use_rs_d = id_use_rs && id_valid && !stall_raw;
      ex_use_rt_d = id_use_rt && id_valid && !stall_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recs_q      <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
    end else begin
      recs_q      <= recs_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_raw && !mem_freeze && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (mem_freeze && freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (DEPTH=3/LOAD_STAGE=2 and
// DEPTH=4/LOAD_STAGE=3) share one stimulus stream and are checked every
// cycle against an instruction-level reference model, plus directed checks.
module tb_hazard_scoreboard;

  localparam int DEP [2] = '{3, 4};
  localparam int LS  [2] = '{2, 3};
  localparam int BW  [2] = '{2, 2};

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_reg_wr, id_mem_rd;
  logic id_is_branch, id_jump, id_br_taken, mem_ready;
  logic [4:0] id_rs, id_rt, id_rd;

  logic [1:0] pcw, ifw, bub, fl, fz;
  logic [1:0][1:0] fa, fb;
  logic [1:0][31:0] scnt, fcnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(2), .BR_WAIT(2), .RA_W(5)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_is_branch(id_is_branch), .id_jump(id_jump),
    .id_br_taken(id_br_taken), .mem_ready(mem_ready), .pc_write(pcw[0]),
    .ifid_write(ifw[0]), .idex_bubble(bub[0]), .ifid_flush(fl[0]), .freeze(fz[0]),
    .fwd_a(fa[0]), .fwd_b(fb[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt[0]), .freeze_cnt(fcnt[0])
`endif
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_STAGE(3), .BR_WAIT(2), .RA_W(5)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_is_branch(id_is_branch), .id_jump(id_jump),
    .id_br_taken(id_br_taken), .mem_ready(mem_ready), .pc_write(pcw[1]),
    .ifid_write(ifw[1]), .idex_bubble(bub[1]), .ifid_flush(fl[1]), .freeze(fz[1]),
    .fwd_a(fa[1]), .fwd_b(fb[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt[1]), .freeze_cnt(fcnt[1])
`endif
  );

`ifndef HAZARD_PERF_CNT_EN
  assign scnt = '0;
  assign fcnt = '0;
`endif

  // Reference model: instructions in flight per configuration, [c][stage].
  bit mv [2][4];
  bit mwr[2][4];
  bit mld[2][4];
  int mrd[2][4];
  int mrs[2], mrt[2];
  bit murs[2], murt[2];
  logic [31:0] msc[2], mfc[2];

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        mv[c][k] = 1'b0; mwr[c][k] = 1'b0; mld[c][k] = 1'b0; mrd[c][k] = 0;
      end
      mrs[c] = 0; mrt[c] = 0; murs[c] = 1'b0; murt[c] = 1'b0;
      msc[c] = '0; mfc[c] = '0;
    end
  endtask

  // Nearest in-flight instruction at or after stage 'from' that writes src.
  function automatic int nearest(int c, int src, bit used, int from);
    if (!used) return -1;
    for (int k = from; k < DEP[c]; k++)
      if (mv[c][k] && mwr[c][k] && mrd[c][k] != 0 && mrd[c][k] == src) return k;
    return -1;
  endfunction

  function automatic bit src_stalls(int c, int k);
    if (k < 0) return 1'b0;
    if (mld[c][k] && k + 1 < LS[c]) return 1'b1;
    if (id_is_branch && k < BW[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall(int c);
    if (!id_valid) return 1'b0;
    return src_stalls(c, nearest(c, int'(id_rs), id_use_rs, 0)) ||
           src_stalls(c, nearest(c, int'(id_rt), id_use_rt, 0));
  endfunction

  function automatic bit exp_freeze(int c);
    return !mem_ready && mv[c][1] && mld[c][1];
  endfunction

  function automatic int exp_fwd(int c, int src, bit used);
    int k;
    k = nearest(c, src, used, 1);
    if (k < 0) return 0;
    if (mld[c][k] && k < LS[c]) return 0;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_check();
    for (int c = 0; c < 2; c++) begin
      bit st, fr, fls;
      int ea, eb;
      fr  = exp_freeze(c);
      st  = exp_stall(c);
      fls = ((id_br_taken && id_is_branch) || id_jump) && !st && !fr;
      ea  = exp_fwd(c, mrs[c], murs[c]);
      eb  = exp_fwd(c, mrt[c], murt[c]);
      if (rst) begin
        fr = 1'b0; st = 1'b0; fls = 1'b0; ea = 0; eb = 0;
      end
      chk($sformatf("d%0d_pc_write", c), 32'(pcw[c]), 32'(!(fr || st)));
      chk($sformatf("d%0d_ifid_write", c), 32'(ifw[c]), 32'(!(fr || st)));
      chk($sformatf("d%0d_idex_bubble", c), 32'(bub[c]), 32'(st && !fr));
      chk($sformatf("d%0d_ifid_flush", c), 32'(fl[c]), 32'(fls));
      chk($sformatf("d%0d_freeze", c), 32'(fz[c]), 32'(fr));
      chk($sformatf("d%0d_fwd_a", c), 32'(fa[c]), 32'(ea));
      chk($sformatf("d%0d_fwd_b", c), 32'(fb[c]), 32'(eb));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("d%0d_stall_cnt", c), scnt[c], msc[c]);
      chk($sformatf("d%0d_freeze_cnt", c), fcnt[c], mfc[c]);
`endif
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    bit st[2], fr[2];
    for (int c = 0; c < 2; c++) begin
      st[c] = exp_stall(c);
      fr[c] = exp_freeze(c);
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!fr[c]) begin
          for (int k = DEP[c] - 1; k > 0; k--) begin
            mv[c][k] = mv[c][k-1]; mwr[c][k] = mwr[c][k-1];
            mld[c][k] = mld[c][k-1]; mrd[c][k] = mrd[c][k-1];
          end
          mv[c][0]  = id_valid && !st[c];
          mrd[c][0] = int'(id_rd);
          mwr[c][0] = id_reg_wr;
          mld[c][0] = id_mem_rd;
          mrs[c]    = int'(id_rs);
          mrt[c]    = int'(id_rt);
          murs[c]   = id_use_rs && mv[c][0];
          murt[c]   = id_use_rt && mv[c][0];
        end
        if (st[c] && !fr[c] && msc[c] != '1) msc[c] = msc[c] + 1;
        if (fr[c] && mfc[c] != '1) mfc[c] = mfc[c] + 1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit wr, input bit ld, input bit br, input bit tk,
                        input bit jmp);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = 5'(rd); id_reg_wr = wr; id_mem_rd = ld; id_is_branch = br;
    id_br_taken = tk; id_jump = jmp;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    settle();
    chk("reset_pc_write", 32'(pcw[0]), 32'd1);
    chk("reset_bubble", 32'(bub[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // lw $2 ; add $3,$2,$4 held in ID until both configurations accept it
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    cycle();
    set_id(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0);
    settle();
    chk("lu_d3_stall_pc", 32'(pcw[0]), 32'd0);
    chk("lu_d3_stall_bubble", 32'(bub[0]), 32'd1);
    chk("lu_d4_stall1_pc", 32'(pcw[1]), 32'd0);
    advance();
    settle();
    chk("lu_d3_release_pc", 32'(pcw[0]), 32'd1);
    chk("lu_d4_stall2_pc", 32'(pcw[1]), 32'd0);
    advance();
    settle();
    chk("lu_d3_fwd_a", 32'(fa[0]), 32'd2);
    chk("lu_d4_release_pc", 32'(pcw[1]), 32'd1);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("lu_d4_fwd_a", 32'(fa[1]), 32'd3);
    advance();
    idle(4);

    // add $2 ; sub $5,$2,$2
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    cycle();
    set_id(1, 2, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    settle();
    chk("alu_no_stall", 32'(pcw[0]), 32'd1);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("alu_fwd_a", 32'(fa[0]), 32'd1);
    chk("alu_fwd_b", 32'(fb[0]), 32'd1);
    chk("alu_d4_fwd_a", 32'(fa[1]), 32'd1);
    advance();
    idle(4);

    // write $0 ; read $0
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0);
    settle();
    chk("r0_no_stall", 32'(pcw[0]), 32'd1);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("r0_fwd_a", 32'(fa[0]), 32'd0);
    advance();
    idle(4);

    // add $2 ; beq $2,$2 taken
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    cycle();
    set_id(1, 2, 2, 1, 1, 0, 0, 0, 1, 1, 0);
    settle();
    chk("br_stall1", 32'(pcw[0]), 32'd0);
    advance();
    settle();
    chk("br_stall2", 32'(pcw[0]), 32'd0);
    advance();
    settle();
    chk("br_flush", 32'(fl[0]), 32'd1);
    advance();
    idle(4);

    // load sitting in stage 1 while memory is busy, then again with a taken branch in ID
    for (int rep = 0; rep < 2; rep++) begin
      set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
      cycle();
      idle(1);
      mem_ready = 1'b0;
      if (rep == 0) set_id(1, 6, 7, 1, 1, 5, 1, 0, 0, 0, 0);
      else          set_id(1, 9, 9, 1, 1, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
        settle();
        chk("frz_freeze", 32'(fz[0]), 32'd1);
        chk("frz_pc_hold", 32'(pcw[0]), 32'd0);
        chk("frz_no_flush", 32'(fl[0]), 32'd0);
        advance();
      end
      mem_ready = 1'b1;
      settle();
      chk("frz_release", 32'(fz[0]), 32'd0);
      if (rep == 1) chk("frz_flush_after", 32'(fl[0]), 32'd1);
      advance();
      idle(4);
    end

    // reset in the middle of a load-use stall
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    cycle();
    set_id(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0);
    settle();
    chk("rst_pre_stall", 32'(pcw[0]), 32'd0);
    advance();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    model_check();
    chk("rst_mid_pc_d3", 32'(pcw[0]), 32'd1);
    chk("rst_mid_pc_d4", 32'(pcw[1]), 32'd1);
    chk("rst_mid_bubble", 32'(bub[1]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", scnt[0], 32'd0);
`endif
    advance();
    rst = 1'b0;
    idle(2);

    // randomized traffic over a small register window to force many hazards
    for (int i = 0; i < 600; i++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_use_rs    = ($urandom_range(0, 3) != 0);
      id_use_rt    = ($urandom_range(0, 3) != 0);
      id_reg_wr    = ($urandom_range(0, 9) < 7);
      id_mem_rd    = ($urandom_range(0, 9) < 3);
      id_is_branch = ($urandom_range(0, 9) < 2);
      id_br_taken  = ($urandom_range(0, 1) == 1);
      id_jump      = ($urandom_range(0, 19) == 0);
      mem_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
